// File: rtl/div_mc_ctrl.sv
// div_mc_ctrl: multicycle launch/capture controller around a combinational divider
//
// Accepts an operand pair on in_valid/in_ready, drives div_a/div_b from registers and
// holds them for LATENCY cycles, then captures div_quot/div_rem/div_by_0 into out_* and
// presents them on out_valid/out_ready.
// Optional: define DIV_MC_OVF_DETECT_EN to flag most-negative / -1 on out_ovf (TC_MODE=1).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b        operand handshake
//   div_a/div_b                registered operands to the divider
//   div_quot/div_rem/div_by_0  divider results
//   out_valid/out_ready        result handshake
//   out_quot/out_rem/out_dz/out_ovf    registered results
module div_mc_ctrl #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 16,
    parameter int TC_MODE = 0,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_a,
    input  logic [B_WIDTH-1:0] in_b,
    output logic [A_WIDTH-1:0] div_a,
    output logic [B_WIDTH-1:0] div_b,
    input  logic [A_WIDTH-1:0] div_quot,
    input  logic [B_WIDTH-1:0] div_rem,
    input  logic               div_by_0,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] out_quot,
    output logic [B_WIDTH-1:0] out_rem,
    output logic               out_dz,
    output logic               out_ovf
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (LATENCY < 1 || LATENCY > 15 || (TC_MODE != 0 && TC_MODE != 1)) begin : g_bad_param
        $error("div_mc_ctrl: LATENCY must be 1..15 and TC_MODE 0 or 1");
    end

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       w_capture;

    assign in_ready  = r_state == IDLE;
    assign w_capture = r_state == HOLD && r_cnt == 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            div_a     <= '0;
            div_b     <= '0;
            out_quot  <= '0;
            out_rem   <= '0;
            out_dz    <= 1'b0;
            out_valid <= 1'b0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                div_a   <= in_a;
                div_b   <= in_b;
                r_cnt   <= 4'(LATENCY - 1);
                r_state <= HOLD;
            end
        end else if (r_state == HOLD) begin
            if (w_capture) begin
                out_quot  <= div_quot;
                out_rem   <= div_rem;
                out_dz    <= div_by_0;
                out_valid <= 1'b1;
                r_state   <= DONE;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
        end
    end

`ifdef DIV_MC_OVF_DETECT_EN
    // Evaluated on the held operands, so it rides the same multicycle window as the divider.
    logic w_ovf;
    assign w_ovf = TC_MODE == 1 && div_a == {1'b1, {(A_WIDTH-1){1'b0}}} && &div_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_ovf <= 1'b0;
        else if (w_capture)
            out_ovf <= w_ovf;
    end
`else
    assign out_ovf = 1'b0;
`endif
endmodule
